// File: rtl/alu_md.sv
// Execute-stage ALU: combinational R-type decode plus an iterative
// multiply/divide unit with HI/LO registers and a stall handshake.
//
// state | meaning
// IDLE  | no multiply/divide pending; HI/LO stable
// CALC  | WIDTH iterations of shift-add multiply or restoring divide
// FIX   | sign correction; HI/LO written at the end of this cycle
module alu_md #(
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     alu_valid,
  input  logic [5:0]               op,
  input  logic [5:0]               func,
  input  logic [$clog2(WIDTH)-1:0] shamt,
  input  logic [WIDTH-1:0]         alu_data_1,
  input  logic [WIDTH-1:0]         alu_data_2,
  output logic [WIDTH-1:0]         alu_result,
  output logic                     zero,
  output logic                     overflow,
  output logic                     stall,
  output logic                     md_busy,
  output logic                     md_done,
  output logic [WIDTH-1:0]         hi,
  output logic [WIDTH-1:0]         lo
);
  localparam int SHW = $clog2(WIDTH);

  localparam logic [5:0] F_SLL  = 6'b000000, F_SRL  = 6'b000010, F_SRA  = 6'b000011;
  localparam logic [5:0] F_MFHI = 6'b010000, F_MFLO = 6'b010010;
  localparam logic [5:0] F_MULT = 6'b011000, F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV  = 6'b011010, F_DIVU  = 6'b011011;
  localparam logic [5:0] F_ADD  = 6'b100000, F_ADDU = 6'b100001;
  localparam logic [5:0] F_SUB  = 6'b100010, F_SUBU = 6'b100011;
  localparam logic [5:0] F_AND  = 6'b100100, F_OR   = 6'b100101;
  localparam logic [5:0] F_XOR  = 6'b100110, F_NOR  = 6'b100111;
  localparam logic [5:0] F_SLT  = 6'b101010, F_SLTU = 6'b101011;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;

  state_t               state_q, state_d;
  logic [SHW-1:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0]     a_q, a_d;
  logic [2*WIDTH-1:0]   p_q, p_d;
  logic                 is_div_q, is_div_d;
  logic                 neg_lo_q, neg_lo_d;
  logic                 neg_hi_q, neg_hi_d;
  logic [WIDTH-1:0]     hi_q, hi_d, lo_q, lo_d;
  logic                 done_q, done_d;

  logic                 rtype, md_op, hilo_rd, issue_md;
  logic [WIDTH-1:0]     sum, diff;
  logic                 signed_op, sign_1, sign_2;
  logic [WIDTH-1:0]     mag_1, mag_2;
  logic [WIDTH:0]       mul_sum, div_r, div_diff;
  logic [2*WIDTH-1:0]   prod_fix;

  assign rtype    = (op == 6'b000000);
  assign md_op    = rtype && (func inside {F_MULT, F_MULTU, F_DIV, F_DIVU});
  assign hilo_rd  = rtype && (func inside {F_MFHI, F_MFLO});
  assign md_busy  = (state_q != S_IDLE);
  assign issue_md = alu_valid && md_op && !md_busy;
  assign stall    = md_busy && alu_valid && (md_op || hilo_rd);
  assign md_done  = done_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

  assign sum  = alu_data_1 + alu_data_2;
  assign diff = alu_data_1 - alu_data_2;

  always_comb begin
    alu_result = '0;
    overflow   = 1'b0;
    if (rtype) begin
      case (func)
        F_ADD: begin
          alu_result = sum;
          overflow   = (alu_data_1[WIDTH-1] == alu_data_2[WIDTH-1]) &&
                       (sum[WIDTH-1] != alu_data_1[WIDTH-1]);
        end
        F_ADDU: alu_result = sum;
        F_SUB: begin
          alu_result = diff;
          overflow   = (alu_data_1[WIDTH-1] != alu_data_2[WIDTH-1]) &&
                       (diff[WIDTH-1] != alu_data_1[WIDTH-1]);
        end
        F_SUBU: alu_result = diff;
        F_AND:  alu_result = alu_data_1 & alu_data_2;
        F_OR:   alu_result = alu_data_1 | alu_data_2;
        F_XOR:  alu_result = alu_data_1 ^ alu_data_2;
        F_NOR:  alu_result = ~(alu_data_1 | alu_data_2);
        F_SLT:  alu_result = {{(WIDTH-1){1'b0}}, ($signed(alu_data_1) < $signed(alu_data_2))};
        F_SLTU: alu_result = {{(WIDTH-1){1'b0}}, (alu_data_1 < alu_data_2)};
        F_SLL:  alu_result = alu_data_2 << shamt;
        F_SRL:  alu_result = alu_data_2 >> shamt;
        F_SRA:  alu_result = $signed(alu_data_2) >>> shamt;
        F_MFHI: alu_result = hi_q;
        F_MFLO: alu_result = lo_q;
        default: alu_result = '0;
      endcase
    end
  end

  assign zero = ~|alu_result;

  // Odd function codes (multu/divu) are the unsigned variants.
  assign signed_op = ~func[0];
  assign sign_1    = signed_op & alu_data_1[WIDTH-1];
  assign sign_2    = signed_op & alu_data_2[WIDTH-1];
  assign mag_1     = sign_1 ? -alu_data_1 : alu_data_1;
  assign mag_2     = sign_2 ? -alu_data_2 : alu_data_2;

  // p_q holds {partial product, multiplier} or {remainder, dividend/quotient}.
  assign mul_sum  = {1'b0, p_q[2*WIDTH-1:WIDTH]} + {1'b0, (p_q[0] ? a_q : '0)};
  assign div_r    = {p_q[2*WIDTH-1:WIDTH], p_q[WIDTH-1]};
  assign div_diff = div_r - {1'b0, a_q};
  assign prod_fix = neg_lo_q ? -p_q : p_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    p_d      = p_q;
    is_div_d = is_div_q;
    neg_lo_d = neg_lo_q;
    neg_hi_d = neg_hi_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (issue_md) begin
          state_d  = S_CALC;
          cnt_d    = SHW'(WIDTH-1);
          is_div_d = func[1];
          neg_lo_d = sign_1 ^ sign_2;
          if (func[1]) begin
            a_d      = mag_2;
            p_d      = {{WIDTH{1'b0}}, mag_1};
            neg_hi_d = sign_1;
          end else begin
            a_d      = mag_1;
            p_d      = {{WIDTH{1'b0}}, mag_2};
            neg_hi_d = 1'b0;
          end
        end
      end
      S_CALC: begin
        if (is_div_q) begin
          if (!div_diff[WIDTH])
            p_d = {div_diff[WIDTH-1:0], p_q[WIDTH-2:0], 1'b1};
          else
            p_d = {div_r[WIDTH-1:0], p_q[WIDTH-2:0], 1'b0};
        end else begin
          p_d = {mul_sum, p_q[WIDTH-1:1]};
        end
        if (cnt_q == '0) state_d = S_FIX;
        else             cnt_d   = cnt_q - SHW'(1);
      end
      S_FIX: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
        if (is_div_q) begin
          lo_d = neg_lo_q ? -p_q[WIDTH-1:0] : p_q[WIDTH-1:0];
          hi_d = neg_hi_q ? -p_q[2*WIDTH-1:WIDTH] : p_q[2*WIDTH-1:WIDTH];
        end else begin
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      a_q      <= '0;
      p_q      <= '0;
      is_div_q <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      p_q      <= p_d;
      is_div_q <= is_div_d;
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
    end
  end
endmodule

// File: tb/tb_alu_md.sv
// Scoreboard bench for alu_md: the driver pushes expectations from a
// plain-arithmetic reference model, the monitor pops and compares.
module tb_alu_md;
  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          alu_valid;
  logic [5:0]    op, func;
  logic [4:0]    shamt;
  logic [W-1:0]  alu_data_1, alu_data_2, alu_result, hi, lo;
  logic          zero, overflow, stall, md_busy, md_done;

  always #5 clk = ~clk;

  alu_md #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .alu_valid(alu_valid), .op(op), .func(func),
    .shamt(shamt), .alu_data_1(alu_data_1), .alu_data_2(alu_data_2),
    .alu_result(alu_result), .zero(zero), .overflow(overflow), .stall(stall),
    .md_busy(md_busy), .md_done(md_done), .hi(hi), .lo(lo)
  );

  typedef struct {
    logic [5:0]   op;
    logic [5:0]   func;
    logic [W-1:0] res;
    logic         ovf;
    int           rd;
  } comb_exp_t;

  typedef struct {
    logic [5:0]   func;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
  } md_exp_t;

  comb_exp_t comb_q[$];
  md_exp_t   md_q[$];
  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic string fname(input logic [5:0] o, input logic [5:0] f);
    if (o != 6'd0) return "non_rtype";
    case (f)
      6'h20: return "add";   6'h21: return "addu";  6'h22: return "sub";
      6'h23: return "subu";  6'h24: return "and";   6'h25: return "or";
      6'h26: return "xor";   6'h27: return "nor";   6'h2a: return "slt";
      6'h2b: return "sltu";  6'h00: return "sll";   6'h02: return "srl";
      6'h03: return "sra";   6'h10: return "mfhi";  6'h12: return "mflo";
      6'h18: return "mult";  6'h19: return "multu"; 6'h1a: return "div";
      6'h1b: return "divu";
      default: return "undef";
    endcase
  endfunction

  function automatic bit is_md(input logic [5:0] o, input logic [5:0] f);
    return (o == 6'd0) && (f inside {6'h18, 6'h19, 6'h1a, 6'h1b});
  endfunction

  function automatic void comb_model(input logic [5:0] o, input logic [5:0] f,
                                     input logic [4:0] sh, input logic [W-1:0] a,
                                     input logic [W-1:0] b, output logic [W-1:0] r,
                                     output logic v, output int rd);
    longint s;
    r = '0; v = 1'b0; rd = 0;
    if (o == 6'd0) begin
      case (f)
        6'h20: begin s = longint'($signed(a)) + longint'($signed(b)); r = a + b;
                     v = (s != longint'($signed(r))); end
        6'h21: r = a + b;
        6'h22: begin s = longint'($signed(a)) - longint'($signed(b)); r = a - b;
                     v = (s != longint'($signed(r))); end
        6'h23: r = a - b;
        6'h24: r = a & b;
        6'h25: r = a | b;
        6'h26: r = a ^ b;
        6'h27: r = ~(a | b);
        6'h2a: r = ($signed(a) < $signed(b)) ? 1 : 0;
        6'h2b: r = (a < b) ? 1 : 0;
        6'h00: r = b << sh;
        6'h02: r = b >> sh;
        6'h03: begin s = longint'($signed(b)) >>> sh; r = s[W-1:0]; end
        6'h10: rd = 1;
        6'h12: rd = 2;
        default: r = '0;
      endcase
    end
  endfunction

  function automatic void md_model(input logic [5:0] f, input logic [W-1:0] a,
                                   input logic [W-1:0] b, output logic [W-1:0] h,
                                   output logic [W-1:0] l);
    longint p, q, rm;
    logic [63:0] pu;
    h = '0; l = '0;
    case (f)
      6'h18: begin p = longint'($signed(a)) * longint'($signed(b)); h = p[63:32]; l = p[31:0]; end
      6'h19: begin pu = {32'h0, a} * {32'h0, b}; h = pu[63:32]; l = pu[31:0]; end
      6'h1a: begin
        if (b == '0) begin
          h = a;
          l = a[W-1] ? 32'h1 : 32'hFFFF_FFFF;
        end else begin
          q = longint'($signed(a)) / longint'($signed(b));
          rm = longint'($signed(a)) % longint'($signed(b));
          l = q[31:0]; h = rm[31:0];
        end
      end
      default: begin
        if (b == '0) begin h = a; l = 32'hFFFF_FFFF; end
        else begin l = a / b; h = a % b; end
      end
    endcase
  endfunction

  task automatic issue(input logic [5:0] o, input logic [5:0] f, input logic [4:0] sh,
                       input logic [W-1:0] a, input logic [W-1:0] b, output int stalls);
    comb_exp_t ce;
    md_exp_t   me;
    alu_valid = 1'b1; op = o; func = f; shamt = sh; alu_data_1 = a; alu_data_2 = b;
    ce.op = o; ce.func = f;
    comb_model(o, f, sh, a, b, ce.res, ce.ovf, ce.rd);
    comb_q.push_back(ce);
    stalls = 0;
    forever begin
      @(negedge clk);
      if (!stall) break;
      stalls++;
      if (stalls > 4 * W) begin
        checks++; failures++;
        $display("FAIL stall_timeout actual=%0d required<=%0d", stalls, 4 * W);
        break;
      end
    end
    if (is_md(o, f)) begin
      me.func = f;
      md_model(f, a, b, me.hi, me.lo);
      md_q.push_back(me);
    end
    @(posedge clk);
    #1;
    alu_valid = 1'b0;
  endtask

  // Monitor: timing model of the multiply/divide handshake plus scoreboard pops.
  int           busy_left = 0;
  logic         done_exp = 1'b0;
  logic [W-1:0] mhi = '0, mlo = '0;

  always @(negedge clk) begin : mon
    comb_exp_t ce;
    md_exp_t   me;
    logic      exp_stall, mdf, rdf, accept;
    logic [W-1:0] exp_r;
    if (!rst_n) begin
      chk("rst_md_busy", md_busy, 0);
      chk("rst_md_done", md_done, 0);
      chk("rst_stall", stall, 0);
      chk("rst_hi", hi, 0);
      chk("rst_lo", lo, 0);
      busy_left = 0; done_exp = 1'b0; mhi = '0; mlo = '0;
      md_q.delete();
    end else begin
      if (md_done && md_q.size() > 0) begin
        me = md_q.pop_front();
        mhi = me.hi; mlo = me.lo;
      end
      chk("md_busy", md_busy, busy_left > 0);
      chk("md_done", md_done, done_exp);
      chk("hi", hi, mhi);
      chk("lo", lo, mlo);
      mdf = is_md(op, func);
      rdf = (op == 6'd0) && (func inside {6'h10, 6'h12});
      exp_stall = (busy_left > 0) && alu_valid && (mdf || rdf);
      chk("stall", stall, exp_stall);
      if (alu_valid && !exp_stall) begin
        if (comb_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL comb_queue_empty actual=0 required>=1");
        end else begin
          ce = comb_q.pop_front();
          exp_r = (ce.rd == 1) ? mhi : (ce.rd == 2) ? mlo : ce.res;
          chk({fname(ce.op, ce.func), "_result"}, alu_result, exp_r);
          chk({fname(ce.op, ce.func), "_zero"}, zero, exp_r == '0);
          chk({fname(ce.op, ce.func), "_overflow"}, overflow, ce.ovf);
        end
      end
      accept = alu_valid && mdf && (busy_left == 0);
      done_exp = (busy_left == 1);
      if (busy_left > 0) busy_left--;
      if (accept) busy_left = W + 1;
    end
  end

  function automatic logic [W-1:0] pick_operand();
    case ($urandom_range(0, 6))
      0: return '0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'h7FFF_FFFF;
      4: return W'($urandom_range(0, 20));
      default: return W'($urandom);
    endcase
  endfunction

  initial begin : drv
    int st;
    logic [5:0] funcs [19] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                               6'h2a, 6'h2b, 6'h00, 6'h02, 6'h03, 6'h10, 6'h12,
                               6'h18, 6'h19, 6'h1a, 6'h1b};
    logic [5:0] o, f;
    int n;
    alu_valid = 1'b0; op = '0; func = '0; shamt = '0; alu_data_1 = '0; alu_data_2 = '0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;

    issue(6'd0, 6'h20, 5'd0, 32'h7FFF_FFFF, 32'h1, st);
    issue(6'd0, 6'h21, 5'd0, 32'h7FFF_FFFF, 32'h1, st);
    issue(6'd0, 6'h22, 5'd0, 32'd5, 32'd5, st);
    issue(6'd0, 6'h22, 5'd0, 32'h8000_0000, 32'h1, st);
    issue(6'd0, 6'h23, 5'd0, 32'h8000_0000, 32'h1, st);
    issue(6'd0, 6'h24, 5'd0, 32'hF0F0_F0F0, 32'h0F0F_0F0F, st);
    issue(6'd0, 6'h27, 5'd0, 32'h0, 32'h0, st);
    issue(6'd0, 6'h03, 5'd4, 32'h0, 32'h8000_0000, st);
    issue(6'd0, 6'h2a, 5'd0, 32'hFFFF_FFFF, 32'h1, st);
    issue(6'd0, 6'h2b, 5'd0, 32'hFFFF_FFFF, 32'h1, st);
    issue(6'd0, 6'h00, 5'd31, 32'h0, 32'h3, st);
    issue(6'd0, 6'h02, 5'd4, 32'h0, 32'h8000_0000, st);
    issue(6'h08, 6'h20, 5'd0, 32'h1, 32'h2, st);
    issue(6'd0, 6'h3f, 5'd0, 32'h1, 32'h2, st);

    issue(6'd0, 6'h18, 5'd0, 32'hFFFF_FFFD, 32'h5, st);
    issue(6'd0, 6'h10, 5'd0, 32'h0, 32'h0, st);
    chk("mfhi_stall_cycles", st, W + 1);
    chk("mult_hi", hi, 32'hFFFF_FFFF);
    chk("mult_lo", lo, 32'hFFFF_FFF1);

    issue(6'd0, 6'h19, 5'd0, 32'hFFFF_FFFD, 32'h5, st);
    issue(6'd0, 6'h20, 5'd0, 32'h11, 32'h22, st);
    chk("add_during_busy_stall", st, 0);
    issue(6'd0, 6'h12, 5'd0, 32'h0, 32'h0, st);
    chk("mflo_stall_cycles", st, W);
    chk("multu_hi", hi, 32'h0000_0004);
    chk("multu_lo", lo, 32'hFFFF_FFF1);

    issue(6'd0, 6'h1a, 5'd0, 32'hFFFF_FFF9, 32'h2, st);
    issue(6'd0, 6'h12, 5'd0, 32'h0, 32'h0, st);
    chk("div_lo", lo, 32'hFFFF_FFFD);
    chk("div_hi", hi, 32'hFFFF_FFFF);
    issue(6'd0, 6'h1b, 5'd0, 32'h0000_000A, 32'h0, st);
    issue(6'd0, 6'h10, 5'd0, 32'h0, 32'h0, st);
    chk("divu0_lo", lo, 32'hFFFF_FFFF);
    chk("divu0_hi", hi, 32'h0000_000A);
    issue(6'd0, 6'h1a, 5'd0, 32'h8000_0000, 32'hFFFF_FFFF, st);
    issue(6'd0, 6'h12, 5'd0, 32'h0, 32'h0, st);
    chk("divmin_lo", lo, 32'h8000_0000);
    chk("divmin_hi", hi, 32'h0);
    issue(6'd0, 6'h18, 5'd0, 32'h1234_5678, 32'h9ABC_DEF0, st);
    issue(6'd0, 6'h1a, 5'd0, 32'hFFFF_FFF9, 32'h0, st);
    chk("back_to_back_stall", st, W + 1);
    issue(6'd0, 6'h10, 5'd0, 32'h0, 32'h0, st);

    // Abort a divide ten cycles in.
    issue(6'd0, 6'h1b, 5'd0, 32'd100, 32'd7, st);
    repeat (9) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_md_busy", md_busy, 0);
    chk("abort_hi", hi, 0);
    chk("abort_lo", lo, 0);
    chk("abort_md_done", md_done, 0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    issue(6'd0, 6'h1a, 5'd0, 32'hFFFF_FF9C, 32'd7, st);
    issue(6'd0, 6'h12, 5'd0, 32'h0, 32'h0, st);
    chk("after_reset_div_lo", lo, 32'hFFFF_FFF2);
    chk("after_reset_div_hi", hi, 32'hFFFF_FFFE);

    for (int i = 0; i < 400; i++) begin
      f = ($urandom_range(0, 9) == 0) ? 6'($urandom) : funcs[$urandom_range(0, 18)];
      o = ($urandom_range(0, 15) == 0) ? 6'($urandom_range(1, 63)) : 6'd0;
      issue(o, f, 5'($urandom_range(0, 31)), pick_operand(), pick_operand(), st);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
    end

    n = 0;
    while (md_busy && n < 100) begin
      @(posedge clk); n++;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("comb_queue_left", comb_q.size(), 0);
    chk("md_queue_left", md_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout actual=%0t required<1000000", $time);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1);
  end
endmodule
